// File: rtl/sme_pkg.sv
// Shared types and constants for the SME job scheduler.
package sme_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_BURST,
        S_WAIT,
        S_RESP
    } state_e;

    localparam int STR_MAX_DEF = 32;
    localparam int PAT_MAX_DEF = 9;

    // Job length counters are sized for the engine's store depths
    localparam int STR_LEN_W = 6;
    localparam int PAT_LEN_W = 4;
    localparam int SME_IDX_W = 5;

    localparam logic [7:0] CH_CARET  = 8'h5E;
    localparam logic [7:0] CH_DOT    = 8'h2E;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_SPACE  = 8'h20;

    // Cycles occupied by one burst: engine reset, first string char, remaining chars, idle tail
    function automatic int burst_len(input int str_len, input int pat_len);
        return 2 + str_len + pat_len;
    endfunction

endpackage

// File: rtl/sme_rr_arbiter.sv
// Round-robin arbiter: picks the first active request at or after the pointer.
module sme_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic               any_req,
    output logic [NUM_REQ-1:0] grant_oh,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] cand;
    int               cand_i;

    // Wrap-around search starting at the pointer; first hit wins
    always_comb begin
        any_req   = 1'b0;
        grant_idx = '0;
        grant_oh  = '0;
        cand      = '0;
        cand_i    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_i = int'(ptr_q) + i;
            if (cand_i >= NUM_REQ) begin
                cand_i = cand_i - NUM_REQ;
            end
            cand = IDX_W'(cand_i);
            if (!any_req && req[cand]) begin
                any_req   = 1'b1;
                grant_idx = cand;
            end
        end
        if (any_req) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    // Pointer moves just past the winner so the winner goes to the back of the line
    always_comb begin
        ptr_d = ptr_q;
        if (advance && any_req) begin
            ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Pointer register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sme_job_scheduler.sv
// Shares one SME string-match engine among several requesters, one job at a time.
module sme_job_scheduler
    import sme_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int STR_MAX = STR_MAX_DEF,
    parameter int PAT_MAX = PAT_MAX_DEF,
    parameter int TIMEOUT = 256
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     rq_valid,
    input  logic [8*NUM_REQ-1:0]   rq_data,
    input  logic [NUM_REQ-1:0]     rq_is_pat,
    input  logic [NUM_REQ-1:0]     rq_last,
    output logic [NUM_REQ-1:0]     rq_ready,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic                   rsp_match,
    output logic [SME_IDX_W-1:0]   rsp_index,
    output logic                   rsp_err,
    output logic                   sme_reset,
    output logic [7:0]             sme_chardata,
    output logic                   sme_isstring,
    output logic                   sme_ispattern,
    input  logic                   sme_match,
    input  logic [SME_IDX_W-1:0]   sme_index,
    input  logic                   sme_valid,
    output logic                   busy
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int SIDX_W = $clog2(STR_MAX);
    localparam int PIDX_W = $clog2(PAT_MAX);
    localparam int TMO_W  = $clog2(TIMEOUT + 1);
    localparam int BCNT_W = $clog2(burst_len(STR_MAX, PAT_MAX) + 1);

    localparam logic [STR_LEN_W-1:0] STR_CAP  = STR_LEN_W'(STR_MAX);
    localparam logic [PAT_LEN_W-1:0] PAT_CAP  = PAT_LEN_W'(PAT_MAX);
    localparam logic [TMO_W-1:0]     TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [TMO_W-1:0]     TMO_SAT  = TMO_W'(TIMEOUT);

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       grant_idx_q, grant_idx_d;
    logic [NUM_REQ-1:0]     grant_oh_q, grant_oh_d;
    logic [STR_LEN_W-1:0]   str_len_q, str_len_d;
    logic [PAT_LEN_W-1:0]   pat_len_q, pat_len_d;
    logic                   err_q, err_d;
    logic [BCNT_W-1:0]      bcnt_q, bcnt_d;
    logic [TMO_W-1:0]       wcnt_q, wcnt_d;
    logic                   res_match_q, res_match_d;
    logic [SME_IDX_W-1:0]   res_index_q, res_index_d;
    logic                   res_err_q, res_err_d;
    logic                   sme_reset_q, sme_reset_d;
    logic [7:0]             sme_char_q, sme_char_d;
    logic                   sme_isstr_q, sme_isstr_d;
    logic                   sme_ispat_q, sme_ispat_d;

    logic [7:0]             str_buf [STR_MAX];
    logic [7:0]             pat_buf [PAT_MAX];
    logic                   str_we, pat_we;
    logic [SIDX_W-1:0]      str_wr, str_rd;
    logic [PIDX_W-1:0]      pat_wr, pat_rd;
    logic [BCNT_W-1:0]      str_end, pat_end;

    logic                   arb_any;
    logic [NUM_REQ-1:0]     arb_oh;
    logic [IDX_W-1:0]       arb_idx;

    logic                   sel_valid, sel_is_pat, sel_last;
    logic [7:0]             sel_data;

    sme_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .clk       (clk),
        .rst       (reset),
        .req       (rq_valid),
        .advance   (state_q == S_IDLE),
        .any_req   (arb_any),
        .grant_oh  (arb_oh),
        .grant_idx (arb_idx)
    );

    assign sel_valid  = rq_valid[grant_idx_q];
    assign sel_is_pat = rq_is_pat[grant_idx_q];
    assign sel_last   = rq_last[grant_idx_q];
    assign sel_data   = rq_data[{grant_idx_q, 3'b000} +: 8];

    assign str_wr  = SIDX_W'(str_len_q);
    assign pat_wr  = PIDX_W'(pat_len_q);
    assign str_end = BCNT_W'(str_len_q) + BCNT_W'(1);
    assign pat_end = str_end + BCNT_W'(pat_len_q);
    assign str_rd  = SIDX_W'(bcnt_q - BCNT_W'(1));
    assign pat_rd  = PIDX_W'(bcnt_q - str_end);

    assign rq_ready      = (state_q == S_COLLECT) ? grant_oh_q : '0;
    assign rsp_valid     = (state_q == S_RESP) ? grant_oh_q : '0;
    assign rsp_match     = res_match_q;
    assign rsp_index     = res_index_q;
    assign rsp_err       = res_err_q;
    assign sme_reset     = sme_reset_q;
    assign sme_chardata  = sme_char_q;
    assign sme_isstring  = sme_isstr_q;
    assign sme_ispattern = sme_ispat_q;
    assign busy          = (state_q != S_IDLE);

    // Job FSM: collect, burst into the engine, wait for its verdict, respond
    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        grant_oh_d  = grant_oh_q;
        str_len_d   = str_len_q;
        pat_len_d   = pat_len_q;
        err_d       = err_q;
        bcnt_d      = bcnt_q;
        wcnt_d      = wcnt_q;
        res_match_d = res_match_q;
        res_index_d = res_index_q;
        res_err_d   = res_err_q;
        sme_reset_d = 1'b0;
        sme_char_d  = 8'h00;
        sme_isstr_d = 1'b0;
        sme_ispat_d = 1'b0;
        str_we      = 1'b0;
        pat_we      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (arb_any) begin
                    grant_idx_d = arb_idx;
                    grant_oh_d  = arb_oh;
                    state_d     = S_COLLECT;
                end
            end

            S_COLLECT: begin
                if (sel_valid) begin
                    // Overflowing chars are dropped but the job keeps draining to rq_last
                    if (sel_is_pat) begin
                        if (pat_len_q < PAT_CAP) begin
                            pat_we    = 1'b1;
                            pat_len_d = pat_len_q + 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        if (str_len_q < STR_CAP) begin
                            str_we    = 1'b1;
                            str_len_d = str_len_q + 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    if (sel_last) begin
                        if (err_d || (str_len_d == '0) || (pat_len_d == '0)) begin
                            err_d       = 1'b1;
                            res_match_d = 1'b0;
                            res_index_d = '0;
                            res_err_d   = 1'b1;
                            state_d     = S_RESP;
                        end else begin
                            bcnt_d  = '0;
                            state_d = S_BURST;
                        end
                    end
                end
            end

            S_BURST: begin
                bcnt_d = bcnt_q + 1'b1;
                if (bcnt_q == '0) begin
                    sme_reset_d = 1'b1;
                end else if (bcnt_q == BCNT_W'(1)) begin
                    // Engine sits in IDLE here and latches the first string char unflagged
                    sme_char_d = str_buf[0];
                end else if (bcnt_q < str_end) begin
                    sme_char_d  = str_buf[str_rd];
                    sme_isstr_d = 1'b1;
                end else if (bcnt_q < pat_end) begin
                    sme_char_d  = pat_buf[pat_rd];
                    sme_ispat_d = 1'b1;
                end else begin
                    wcnt_d  = '0;
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                wcnt_d = (wcnt_q == TMO_SAT) ? wcnt_q : wcnt_q + 1'b1;
                if (sme_valid) begin
                    res_match_d = sme_match;
                    res_index_d = sme_index;
                    res_err_d   = 1'b0;
                    state_d     = S_RESP;
                end else if (wcnt_q >= TMO_LAST) begin
                    // Engine never answered: kick it back to a clean state and report error
                    sme_reset_d = 1'b1;
                    res_match_d = 1'b0;
                    res_index_d = '0;
                    res_err_d   = 1'b1;
                    state_d     = S_RESP;
                end
            end

            S_RESP: begin
                str_len_d = '0;
                pat_len_d = '0;
                err_d     = 1'b0;
                state_d   = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and output registers; engine is held in reset while reset is asserted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            grant_idx_q <= '0;
            grant_oh_q  <= '0;
            str_len_q   <= '0;
            pat_len_q   <= '0;
            err_q       <= 1'b0;
            bcnt_q      <= '0;
            wcnt_q      <= '0;
            res_match_q <= 1'b0;
            res_index_q <= '0;
            res_err_q   <= 1'b0;
            sme_reset_q <= 1'b1;
            sme_char_q  <= 8'h00;
            sme_isstr_q <= 1'b0;
            sme_ispat_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            grant_oh_q  <= grant_oh_d;
            str_len_q   <= str_len_d;
            pat_len_q   <= pat_len_d;
            err_q       <= err_d;
            bcnt_q      <= bcnt_d;
            wcnt_q      <= wcnt_d;
            res_match_q <= res_match_d;
            res_index_q <= res_index_d;
            res_err_q   <= res_err_d;
            sme_reset_q <= sme_reset_d;
            sme_char_q  <= sme_char_d;
            sme_isstr_q <= sme_isstr_d;
            sme_ispat_q <= sme_ispat_d;
        end
    end

    // Job character stores; lengths gate every read so contents need no reset
    always_ff @(posedge clk) begin
        if (str_we) begin
            str_buf[str_wr] <= sel_data;
        end
        if (pat_we) begin
            pat_buf[pat_wr] <= sel_data;
        end
    end

endmodule

// File: tb/tb_sme_job_scheduler.sv
// Scoreboard bench for sme_job_scheduler with a behavioural string-match engine.
`timescale 1ns/1ps
module tb_sme_job_scheduler;

    localparam int NR = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NR-1:0]     rq_valid = '0;
    logic [8*NR-1:0]   rq_data = '0;
    logic [NR-1:0]     rq_is_pat = '0;
    logic [NR-1:0]     rq_last = '0;
    logic [NR-1:0]     rq_ready;
    logic [NR-1:0]     rsp_valid;
    logic              rsp_match;
    logic [4:0]        rsp_index;
    logic              rsp_err;
    logic              sme_reset;
    logic [7:0]        sme_chardata;
    logic              sme_isstring;
    logic              sme_ispattern;
    logic              sme_match = 1'b0;
    logic [4:0]        sme_index = '0;
    logic              sme_valid = 1'b0;
    logic              busy;

    sme_job_scheduler #(.NUM_REQ(NR)) dut (
        .clk           (clk),
        .reset         (reset),
        .rq_valid      (rq_valid),
        .rq_data       (rq_data),
        .rq_is_pat     (rq_is_pat),
        .rq_last       (rq_last),
        .rq_ready      (rq_ready),
        .rsp_valid     (rsp_valid),
        .rsp_match     (rsp_match),
        .rsp_index     (rsp_index),
        .rsp_err       (rsp_err),
        .sme_reset     (sme_reset),
        .sme_chardata  (sme_chardata),
        .sme_isstring  (sme_isstring),
        .sme_ispattern (sme_ispattern),
        .sme_match     (sme_match),
        .sme_index     (sme_index),
        .sme_valid     (sme_valid),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct { int r; byte ch; bit pat; bit last; } ch_t;
    typedef struct { int r; bit m; int idx; bit e; } rsp_t;

    ch_t  dq[$];
    rsp_t sb[$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int rst_cycles = 0;
    int rst_cyc = 0;
    int n_isstr = 0;
    int n_ispat = 0;
    int first_flag = -1;
    int last_flag = -1;
    int last_rsp_cyc = 0;
    bit prev_rst = 1'b1;
    bit eng_dead = 1'b0;

    logic [NR-1:0] drv_acc;
    int            drv_r;
    bit            drv_done;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic add_job(input int r, input string s, input string p, input bit mix,
                           input bit m, input int idx, input bit e);
        int is;
        int ip;
        int n;
        ch_t c;
        rsp_t x;
        is = 0;
        ip = 0;
        n = s.len() + p.len();
        for (int k = 0; k < n; k++) begin
            c.r = r;
            c.last = (k == n - 1);
            if (ip < p.len() && (is >= s.len() || (mix && (k % 2 == 0)))) begin
                c.ch = p[ip];
                c.pat = 1'b1;
                ip++;
            end else begin
                c.ch = s[is];
                c.pat = 1'b0;
                is++;
            end
            dq.push_back(c);
        end
        x.r = r;
        x.m = m;
        x.idx = idx;
        x.e = e;
        sb.push_back(x);
    endtask

    task automatic wait_done(input int budget, input string nm);
        int n;
        n = 0;
        while ((sb.size() != 0 || dq.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_done"}, (n < budget), 1);
    endtask

    // Requester driver: each requester presents its oldest pending char
    initial forever begin
        @(negedge clk);
        drv_acc = rq_valid & rq_ready;
        @(posedge clk);
        #1;
        for (int r = 0; r < NR; r++) begin
            if (drv_acc[r]) begin
                drv_done = 1'b0;
                for (int k = 0; k < dq.size(); k++) begin
                    if (!drv_done && dq[k].r == r) begin
                        dq.delete(k);
                        drv_done = 1'b1;
                    end
                end
            end
        end
        rq_valid = '0;
        rq_is_pat = '0;
        rq_last = '0;
        rq_data = '0;
        for (int k = 0; k < dq.size(); k++) begin
            drv_r = dq[k].r;
            if (!rq_valid[drv_r]) begin
                rq_valid[drv_r] = 1'b1;
                rq_is_pat[drv_r] = dq[k].pat;
                rq_last[drv_r] = dq[k].last;
                rq_data[8*drv_r +: 8] = dq[k].ch;
            end
        end
    end

    // Behavioural engine: loads string/pattern from the burst, answers a literal substring search
    byte es [0:63];
    byte ep [0:15];
    int  esl = 0;
    int  epl = 0;
    int  eph = 0;
    int  ecd = 0;

    function automatic int eng_find();
        bit ok;
        for (int i = 0; i + epl <= esl; i++) begin
            ok = 1'b1;
            for (int j = 0; j < epl; j++) begin
                if (es[i + j] != ep[j]) ok = 1'b0;
            end
            if (ok) return i;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        sme_valid <= 1'b0;
        if (sme_reset) begin
            esl <= 0;
            epl <= 0;
            eph <= 1;
        end else begin
            case (eph)
                1: begin
                    es[0] <= sme_chardata;
                    esl <= 1;
                    eph <= 2;
                end
                2: begin
                    if (sme_isstring) begin
                        es[esl] <= sme_chardata;
                        esl <= esl + 1;
                    end else if (sme_ispattern) begin
                        ep[epl] <= sme_chardata;
                        epl <= epl + 1;
                        eph <= 3;
                    end
                end
                3: begin
                    if (sme_ispattern) begin
                        ep[epl] <= sme_chardata;
                        epl <= epl + 1;
                    end else begin
                        ecd <= 3;
                        eph <= 4;
                    end
                end
                4: begin
                    if (ecd == 0) begin
                        if (!eng_dead) begin
                            sme_valid <= 1'b1;
                            sme_match <= (eng_find() >= 0);
                            sme_index <= (eng_find() >= 0) ? 5'(eng_find()) : 5'd0;
                        end
                        eph <= 0;
                    end else begin
                        ecd <= ecd - 1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every response and tracks engine-side activity
    initial forever begin
        rsp_t e;
        @(negedge clk);
        cyc++;
        if (!reset) begin
            if (sme_reset) begin
                rst_cycles++;
                if (!prev_rst) rst_cyc = cyc;
            end
            if (sme_isstring) n_isstr++;
            if (sme_ispattern) n_ispat++;
            if (sme_isstring || sme_ispattern) begin
                if (first_flag < 0) first_flag = cyc;
                last_flag = cyc;
            end
            if (rq_ready != '0) chk("rq_ready_onehot", {31'd0, $onehot(rq_ready)}, 1);
        end
        prev_rst = sme_reset;
        if (rsp_valid != '0) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", {28'd0, rsp_valid}, 0);
            end else begin
                e = sb.pop_front();
                chk("rsp_owner", {28'd0, rsp_valid}, 32'd1 << e.r);
                chk("rsp_match", {31'd0, rsp_match}, {31'd0, e.m});
                chk("rsp_index", {27'd0, rsp_index}, e.idx);
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.e});
                last_rsp_cyc = cyc;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        string pats;
        int pos;
        int snap;
        int t0;
        bit seen;
        pats = "abcdefgh";

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_sme_reset", {31'd0, sme_reset}, 1);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_rsp_valid", {28'd0, rsp_valid}, 0);
        chk("rst_rq_ready", {28'd0, rq_ready}, 0);
        chk("rst_isstring", {31'd0, sme_isstring}, 0);
        chk("rst_ispattern", {31'd0, sme_ispattern}, 0);
        chk("rst_chardata", {24'd0, sme_chardata}, 0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_sme_reset", {31'd0, sme_reset}, 0);
        chk("idle_busy", {31'd0, busy}, 0);

        // All four requesters contend with four jobs each: strict rotation 0,1,2,3,...
        for (int k = 0; k < 4; k++) begin
            for (int r = 0; r < NR; r++) begin
                pos = (r + k) % 8;
                add_job(r, "abcdefgh", pats.substr(pos, pos), 1'b0, 1'b1, pos, 1'b0);
            end
        end
        wait_done(3000, "rr");

        // Reference job: 16-cycle gap-free burst, match at index 6
        n_isstr = 0;
        n_ispat = 0;
        first_flag = -1;
        snap = rst_cycles;
        add_job(0, "hello world", "wor", 1'b0, 1'b1, 6, 1'b0);
        wait_done(500, "hello");
        chk("hello_isstring_cycles", n_isstr, 10);
        chk("hello_ispattern_cycles", n_ispat, 3);
        chk("hello_flag_span", last_flag - first_flag + 1, 13);
        chk("hello_reset_to_first_flag", first_flag - rst_cyc, 2);
        chk("hello_reset_cycles", rst_cycles - snap, 1);

        // Interleaved classes, no match
        add_job(1, "abc", "x", 1'b1, 1'b0, 0, 1'b0);
        wait_done(500, "nomatch");

        // String overflow: drained, rejected, engine untouched
        snap = rst_cycles;
        add_job(2, "abcdefghijklmnopqrstuvwxyzABCDEFG", "a", 1'b0, 1'b0, 0, 1'b1);
        wait_done(500, "str_ovf");
        chk("str_ovf_no_engine_reset", rst_cycles - snap, 0);

        // Pattern overflow, pattern-only and string-only jobs are all rejected
        add_job(3, "abc", "abcdefghij", 1'b0, 1'b0, 0, 1'b1);
        wait_done(500, "pat_ovf");
        add_job(0, "", "ab", 1'b0, 1'b0, 0, 1'b1);
        wait_done(500, "pat_only");
        add_job(1, "abc", "", 1'b0, 1'b0, 0, 1'b1);
        wait_done(500, "str_only");

        // Silent engine: timeout error after TIMEOUT wait cycles plus a reset pulse
        eng_dead = 1'b1;
        snap = rst_cycles;
        t0 = cyc;
        add_job(2, "ab", "a", 1'b0, 1'b0, 0, 1'b1);
        wait_done(1000, "timeout");
        chk("timeout_latency_ok", {31'd0, (last_rsp_cyc - t0) >= 256}, 1);
        chk("timeout_reset_cycles", rst_cycles - snap, 2);
        eng_dead = 1'b0;

        // Reset during burst: job vanishes, engine held in reset
        add_job(3, "hello", "ll", 1'b0, 1'b1, 2, 1'b0);
        void'(sb.pop_back());
        seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            if (sme_isstring) seen = 1'b1;
        end
        chk("midburst_reached", {31'd0, seen}, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_sme_reset", {31'd0, sme_reset}, 1);
        chk("midrst_busy", {31'd0, busy}, 0);
        chk("midrst_rsp_valid", {28'd0, rsp_valid}, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (50) @(negedge clk);
        chk("midrst_idle", {31'd0, busy}, 0);

        // Next job after reset completes normally
        add_job(3, "hello", "ll", 1'b0, 1'b1, 2, 1'b0);
        wait_done(500, "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
